// File: rtl/clb_cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration chain.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY
    } cfg_state_t;

    function automatic int words_per_lut(input int mem_size, input int cfg_width);
        return mem_size / cfg_width;
    endfunction

    function automatic int total_words(input int num_luts, input int mem_size,
                                       input int cfg_width);
        return num_luts * words_per_lut(mem_size, cfg_width);
    endfunction

endpackage

// File: rtl/cfg_checksum.sv
// Modular accumulator with synchronous clear and enable.
module cfg_checksum #(
    parameter int WIDTH = 8
) (
    input  logic             config_clk,
    input  logic             config_rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sum
);

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + din;
        end
    end

endmodule

// File: rtl/lut_config_ctrl.sv
// Loads a LUT daisy-chain from a stream, then recirculates it once
// through the tail to compare checksums.
module lut_config_ctrl
    import clb_cfg_pkg::*;
#(
    parameter int CONFIG_WIDTH = 8,
    parameter int MEM_SIZE     = 16,
    parameter int NUM_LUTS     = 4,
    localparam int TOTAL_WORDS = total_words(NUM_LUTS, MEM_SIZE, CONFIG_WIDTH),
    localparam int CNT_W       = $clog2(TOTAL_WORDS + 1)
) (
    input  logic                    config_clk,
    input  logic                    config_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [CONFIG_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    config_en,
    output logic [CONFIG_WIDTH-1:0] config_in,
    input  logic [CONFIG_WIDTH-1:0] config_out,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [CNT_W-1:0]        word_cnt
);

    cfg_state_t state;

    logic                    load_hs;
    logic                    ver_sh;
    logic                    sum_clr;
    logic                    last_load;
    logic                    last_ver;
    logic [CNT_W-1:0]        vcnt;
    logic [CONFIG_WIDTH-1:0] load_sum;
    logic [CONFIG_WIDTH-1:0] chk_sum;
    logic [CONFIG_WIDTH-1:0] chk_final;

    assign load_hs   = (state == LOAD) && s_valid && !abort;
    assign ver_sh    = (state == VERIFY) && !abort;
    assign sum_clr   = (state == IDLE) && start && !abort;
    assign s_ready   = (state == LOAD) && !abort;
    assign config_en = load_hs || ver_sh;
    assign busy      = (state != IDLE);

    // The load count stays visible for the first verify cycle, then restarts.
    assign vcnt      = (word_cnt == CNT_W'(TOTAL_WORDS)) ? '0 : word_cnt;
    assign last_load = load_hs && (word_cnt == CNT_W'(TOTAL_WORDS - 1));
    assign last_ver  = ver_sh && (vcnt == CNT_W'(TOTAL_WORDS - 1));
    assign chk_final = chk_sum + config_out;

    always_comb begin
        config_in = '0;
        unique case (state)
            LOAD:    config_in = s_data;
            VERIFY:  config_in = config_out;
            default: config_in = '0;
        endcase
    end

    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sum_clr) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (load_hs) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (last_load) state <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        word_cnt <= vcnt + 1'b1;
                        if (last_ver) begin
                            state <= IDLE;
                            done  <= (chk_final == load_sum);
                            err   <= (chk_final != load_sum);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cfg_checksum #(.WIDTH(CONFIG_WIDTH)) u_load_sum (
        .config_clk   (config_clk),
        .config_rst_n (config_rst_n),
        .clr          (sum_clr),
        .en           (load_hs),
        .din          (s_data),
        .sum          (load_sum)
    );

    cfg_checksum #(.WIDTH(CONFIG_WIDTH)) u_chk_sum (
        .config_clk   (config_clk),
        .config_rst_n (config_rst_n),
        .clr          (sum_clr),
        .en           (ver_sh),
        .din          (config_out),
        .sum          (chk_sum)
    );

endmodule

// File: tb/tb_lut_config_ctrl.sv
// Bench for lut_config_ctrl with a 4-word LUT chain model on the tail.
module tb_lut_config_ctrl;

    localparam int TW = 4;

    logic       config_clk = 1'b0;
    logic       config_rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       config_en;
    logic [7:0] config_in;
    logic [7:0] config_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] word_cnt;

    logic [7:0] chain [TW];
    logic       fault = 1'b0;
    int         en_count = 0;
    int         npass = 0;
    int         ntotal = 0;

    lut_config_ctrl #(
        .CONFIG_WIDTH (8),
        .MEM_SIZE     (16),
        .NUM_LUTS     (2)
    ) dut (
        .config_clk   (config_clk),
        .config_rst_n (config_rst_n),
        .start        (start),
        .abort        (abort),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .config_en    (config_en),
        .config_in    (config_in),
        .config_out   (config_out),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .word_cnt     (word_cnt)
    );

    always #5 config_clk = ~config_clk;

    // Chain model: index 0 is the head, TW-1 the tail.
    assign config_out = chain[TW-1] ^ {7'b0, fault};

    always @(posedge config_clk) begin
        if (config_en) begin
            chain[0] <= config_in;
            for (int i = 1; i < TW; i++) chain[i] <= chain[i-1];
            en_count <= en_count + 1;
        end
    end

    task automatic tick();
        @(posedge config_clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        ntotal++;
        if ({busy, done, err, s_ready, config_en} !== 5'b0 ||
            config_in !== 8'h00 || word_cnt !== 3'd0) begin
            $display("FAIL reset: busy=%b done=%b err=%b rdy=%b en=%b in=%h cnt=%0d want all 0",
                     busy, done, err, s_ready, config_en, config_in, word_cnt);
        end else npass++;
        config_rst_n = 1'b1;
        tick();
    endtask

    // Full load plus verify; fault_at selects a verify cycle (1..TW) to corrupt.
    task automatic run_load(input string name, input logic [7:0] w [TW],
                            input int gapmax, input int fault_at);
        int         base;
        int         gap_en;
        logic [7:0] sum;
        logic [7:0] chk;
        logic [7:0] rd [TW];
        logic       exp_done;
        sum  = '0;
        chk  = '0;
        base = en_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        ntotal++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            $display("FAIL %s_start: busy=%b rdy=%b done=%b err=%b want 1 1 0 0",
                     name, busy, s_ready, done, err);
        end else npass++;
        for (int i = 0; i < TW; i++) begin
            int g;
            g = (gapmax == 0) ? 0 : int'($urandom_range(gapmax, 1));
            s_valid = 1'b0;
            gap_en = en_count;
            repeat (g) tick();
            ntotal++;
            if (en_count !== gap_en) begin
                $display("FAIL %s_gap: shifts=%0d want 0", name, en_count - gap_en);
            end else npass++;
            s_valid = 1'b1;
            s_data = w[i];
            sum = sum + w[i];
            tick();
            s_valid = 1'b0;
            ntotal++;
            if (word_cnt !== 3'(i + 1)) begin
                $display("FAIL %s_cnt: word_cnt=%0d want %0d", name, word_cnt, i + 1);
            end else npass++;
        end
        for (int c = 1; c <= TW; c++) begin
            fault = (c == fault_at);
            rd[c-1] = w[c-1] ^ {7'b0, fault};
            chk = chk + rd[c-1];
            if (c == TW) begin
                ntotal++;
                if (busy !== 1'b1 || done !== 1'b0 || config_en !== 1'b1) begin
                    $display("FAIL %s_verify: busy=%b done=%b en=%b want 1 0 1",
                             name, busy, done, config_en);
                end else npass++;
            end
            tick();
        end
        fault = 1'b0;
        exp_done = (chk == sum);
        ntotal++;
        if (busy !== 1'b0 || done !== exp_done || err !== !exp_done) begin
            $display("FAIL %s_status: busy=%b done=%b err=%b want 0 %b %b",
                     name, busy, done, err, exp_done, !exp_done);
        end else npass++;
        ntotal++;
        if (en_count - base !== 2 * TW) begin
            $display("FAIL %s_shifts: got %0d want %0d", name, en_count - base, 2 * TW);
        end else npass++;
        ntotal++;
        if (chain[0] !== rd[3] || chain[1] !== rd[2] ||
            chain[2] !== rd[1] || chain[3] !== rd[0]) begin
            $display("FAIL %s_chain: got %h %h %h %h want %h %h %h %h", name,
                     chain[0], chain[1], chain[2], chain[3], rd[3], rd[2], rd[1], rd[0]);
        end else npass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [TW] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        run_load("b2b", w, 0, 0);
    endtask

    task automatic test_stalled();
        logic [7:0] w [TW] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        run_load("stall", w, 3, 0);
    endtask

    task automatic test_fault();
        logic [7:0] w [TW] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        run_load("fault", w, 0, 2);
    endtask

    task automatic test_overflow();
        logic [7:0] w [TW] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_load("wrap", w, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] w [TW];
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < TW; i++) w[i] = 8'($urandom);
            run_load("rand", w, int'($urandom_range(3, 0)), int'($urandom_range(TW, 0)));
        end
    endtask

    task automatic test_abort();
        logic [7:0] w [TW];
        int base;
        base = en_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'h11;
        tick();
        start = 1'b1;
        s_data = 8'h22;
        tick();
        start = 1'b0;
        ntotal++;
        if (word_cnt !== 3'd2 || busy !== 1'b1) begin
            $display("FAIL abort_ignstart: cnt=%0d busy=%b want 2 1", word_cnt, busy);
        end else npass++;
        abort = 1'b1;
        s_data = 8'h33;
        #1;
        ntotal++;
        if (config_en !== 1'b0 || s_ready !== 1'b0) begin
            $display("FAIL abort_en: en=%b rdy=%b want 0 0", config_en, s_ready);
        end else npass++;
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        ntotal++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || en_count - base !== 2) begin
            $display("FAIL abort_idle: busy=%b done=%b err=%b shifts=%0d want 0 0 0 2",
                     busy, done, err, en_count - base);
        end else npass++;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        ntotal++;
        if (busy !== 1'b0) begin
            $display("FAIL abort_wins: busy=%b want 0", busy);
        end else npass++;
        for (int i = 0; i < TW; i++) w[i] = 8'($urandom);
        run_load("reload", w, 1, 0);
    endtask

    task automatic test_async_reset();
        int base;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < TW; i++) begin
            s_data = 8'($urandom);
            tick();
        end
        s_valid = 1'b0;
        tick();
        #2;
        config_rst_n = 1'b0;
        #1;
        ntotal++;
        if ({busy, done, err, s_ready, config_en} !== 5'b0 ||
            config_in !== 8'h00 || word_cnt !== 3'd0) begin
            $display("FAIL async_rst: busy=%b done=%b err=%b rdy=%b en=%b in=%h cnt=%0d want all 0",
                     busy, done, err, s_ready, config_en, config_in, word_cnt);
        end else npass++;
        tick();
        config_rst_n = 1'b1;
        base = en_count;
        s_valid = 1'b1;
        repeat (5) tick();
        s_valid = 1'b0;
        ntotal++;
        if (en_count - base !== 0 || busy !== 1'b0) begin
            $display("FAIL async_idle: shifts=%0d busy=%b want 0 0", en_count - base, busy);
        end else npass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_stalled();
        test_fault();
        test_overflow();
        test_abort();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
